// File: rtl/id_decode_pkg.sv
// RV32 opcode constants, field positions and the decoded-field bundle
// shared by the decode stage and its field decoder.
package id_decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;
    localparam int IMMU_LSB = 12;

    typedef struct packed {
        logic [11:0] imm;
        logic [19:0] imm_u;
        logic        imm_src;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/id_decode_stage_field_decode.sv
// Combinational RV32 field slicer: register indices, functs and the
// unextended immediate plus its source select for the extender.
module rv_field_decode
    import id_decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] op;

    assign op = instr[6:0];

    always_comb begin
        dec        = '0;
        dec.opcode = op;
        dec.rd     = instr[RD_LSB +: 5];
        dec.funct3 = instr[F3_LSB +: 3];
        dec.rs1    = instr[RS1_LSB +: 5];
        dec.rs2    = instr[RS2_LSB +: 5];
        dec.funct7 = instr[F7_LSB +: 7];
        case (op)
            OP_R: ;
            OP_IMM, OP_LOAD:
                dec.imm = instr[31:20];
            OP_STORE:
                dec.imm = {instr[31:25], instr[11:7]};
            OP_BRANCH:
                dec.imm = {instr[31], instr[7], instr[30:25], instr[11:8]};
            OP_LUI, OP_AUIPC: begin
                dec.imm_src = 1'b1;
                dec.imm_u   = instr[31:IMMU_LSB];
            end
            default:
                dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage with a 2-entry skid (main + skid) so that
// in_ready never depends on out_ready combinationally.
module id_decode_stage
    import id_decode_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [11:0]     Imm,
    output logic [19:0]     Imm_U,
    output logic            Imm_Src,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            illegal
);

    dec_t            main_q;
    logic [PC_W-1:0] main_pc;
    logic            main_valid;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic            skid_valid;

    logic [31:0]     src_instr;
    logic [PC_W-1:0] src_pc;
    dec_t            dec;
    logic            in_xfer;
    logic            out_xfer;
    logic            load_main;
    logic            to_skid;

    // The skid, when occupied, is always older than anything on the input.
    assign src_instr = skid_valid ? skid_instr : in_instr;
    assign src_pc    = skid_valid ? skid_pc : in_pc;

    rv_field_decode u_dec (
        .instr (src_instr),
        .dec   (dec)
    );

    assign in_ready  = !skid_valid && !flush;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_valid && out_ready;
    assign load_main = (!main_valid || out_xfer) && (skid_valid || in_xfer);
    assign to_skid   = in_xfer && main_valid && !out_xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_pc    <= '0;
            main_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (load_main) begin
                main_valid <= 1'b1;
                main_q     <= dec;
                main_pc    <= src_pc;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end
            if (to_skid) begin
                skid_valid <= 1'b1;
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
            end else if (out_xfer) begin
                skid_valid <= 1'b0;
            end
        end
    end

    assign out_valid = main_valid;
    assign out_pc    = main_pc;
    assign Imm       = main_q.imm;
    assign Imm_U     = main_q.imm_u;
    assign Imm_Src   = main_q.imm_src;
    assign rs1       = main_q.rs1;
    assign rs2       = main_q.rs2;
    assign rd        = main_q.rd;
    assign opcode    = main_q.opcode;
    assign funct3    = main_q.funct3;
    assign funct7    = main_q.funct7;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed vector table, skid and
// flush sequences, then random traffic against a queue-based reference.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [11:0] Imm;
    logic [19:0] Imm_U;
    logic        Imm_Src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_decode_stage #(.PC_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .Imm       (Imm),
        .Imm_U     (Imm_U),
        .Imm_Src   (Imm_Src),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .illegal   (illegal)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [11:0] imm;
        logic [19:0] imm_u;
        logic        src;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t vecs[9];

    typedef struct {
        logic [11:0] imm;
        logic [19:0] imm_u;
        logic        src;
        logic        ill;
    } ref_t;

    // Reference immediate rules, written directly from the ISA formats.
    function automatic ref_t ref_dec(input logic [31:0] w);
        ref_t r;
        logic [6:0] op;
        r  = '{default: '0};
        op = w[6:0];
        if (op == 7'h33) begin
        end else if (op == 7'h13 || op == 7'h03) begin
            r.imm = w[31:20];
        end else if (op == 7'h23) begin
            r.imm = {w[31:25], w[11:7]};
        end else if (op == 7'h63) begin
            r.imm = {w[31], w[7], w[30:25], w[11:8]};
        end else if (op == 7'h37 || op == 7'h17) begin
            r.src   = 1'b1;
            r.imm_u = w[31:12];
        end else begin
            r.ill = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[8];
        logic [31:0] w;
        logic [6:0]  o;
        int k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h7F};
        w = $urandom();
        k = $urandom_range(0, 8);
        if (k < 8) begin
            o = ops[k];
        end else begin
            o = 7'($urandom());
        end
        w[6:0] = o;
        return w;
    endfunction

    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];

    initial begin
        ref_t r;
        logic exp_rdy;
        int   sz;

        vecs[0] = '{32'hFFF00293, 32'h100, 12'hFFF, 20'h0, 1'b0, 5'd0, 5'd31, 5'd5, 1'b0};
        vecs[1] = '{32'h123450B7, 32'h104, 12'h0, 20'h12345, 1'b1, 5'd8, 5'd3, 5'd1, 1'b0};
        vecs[2] = '{32'h0021A423, 32'h108, 12'h008, 20'h0, 1'b0, 5'd3, 5'd2, 5'd8, 1'b0};
        vecs[3] = '{32'h0000007F, 32'h10C, 12'h0, 20'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1};
        vecs[4] = '{32'h00812083, 32'h110, 12'h008, 20'h0, 1'b0, 5'd2, 5'd8, 5'd1, 1'b0};
        vecs[5] = '{32'h80000063, 32'h114, 12'h800, 20'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0};
        vecs[6] = '{32'h00000FE3, 32'h118, 12'h40F, 20'h0, 1'b0, 5'd0, 5'd0, 5'd31, 1'b0};
        vecs[7] = '{32'hFFFFF017, 32'h11C, 12'h0, 20'hFFFFF, 1'b1, 5'd31, 5'd31, 5'd0, 1'b0};
        vecs[8] = '{32'h40000033, 32'h120, 12'h0, 20'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00293;
        in_pc     = 32'h40;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_imm", 32'(Imm), 32'd0);
        chk("rst_imm_u", 32'(Imm_U), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        foreach (vecs[i]) begin
            in_valid  = 1'b1;
            in_instr  = vecs[i].instr;
            in_pc     = vecs[i].pc;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_imm", i), 32'(Imm), 32'(vecs[i].imm));
            chk($sformatf("v%0d_imm_u", i), 32'(Imm_U), 32'(vecs[i].imm_u));
            chk($sformatf("v%0d_src", i), 32'(Imm_Src), 32'(vecs[i].src));
            chk($sformatf("v%0d_rs1", i), 32'(rs1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i), 32'(rs2), 32'(vecs[i].rs2));
            chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_ill", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("v%0d_op", i), 32'(opcode), 32'(vecs[i].instr[6:0]));
        end
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Back-pressure: A in main, B in skid, C held by fetch.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h200;
        tick();
        chk("skid_a_valid", 32'(out_valid), 32'd1);
        chk("skid_a_ready", 32'(in_ready), 32'd1);
        in_pc = 32'h204;
        tick();
        chk("skid_full_ready", 32'(in_ready), 32'd0);
        chk("skid_full_pc", out_pc, 32'h200);
        in_pc = 32'h208;
        tick();
        chk("skid_hold_ready", 32'(in_ready), 32'd0);
        chk("skid_hold_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();
        chk("skid_b_pc", out_pc, 32'h204);
        chk("skid_b_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("skid_c_pc", out_pc, 32'h208);
        chk("skid_c_valid", 32'(out_valid), 32'd1);
        tick();
        chk("skid_done", 32'(out_valid), 32'd0);

        // Flush from FULL with a simultaneous input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h300;
        tick();
        in_pc = 32'h304;
        tick();
        in_pc = 32'h308;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_ghost", 32'(out_valid), 32'd0);
        end

        // Random traffic against the queue model, with one mid-run reset.
        q_instr.delete();
        q_pc.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst_n     = !(cyc == 300 || cyc == 301);
            @(negedge clk);
            sz      = q_instr.size();
            exp_rdy = (sz < 2) && !flush;
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rnd_out_valid", 32'(out_valid), 32'(sz > 0));
            if (sz > 0) begin
                r = ref_dec(q_instr[0]);
                chk("rnd_pc", out_pc, q_pc[0]);
                chk("rnd_imm", 32'(Imm), 32'(r.imm));
                chk("rnd_imm_u", 32'(Imm_U), 32'(r.imm_u));
                chk("rnd_src", 32'(Imm_Src), 32'(r.src));
                chk("rnd_ill", 32'(illegal), 32'(r.ill));
                chk("rnd_regs", {17'd0, rs1, rs2, rd},
                    {17'd0, q_instr[0][19:15], q_instr[0][24:20], q_instr[0][11:7]});
                chk("rnd_functs", {22'd0, funct7, funct3},
                    {22'd0, q_instr[0][31:25], q_instr[0][14:12]});
            end
            if (!rst_n || flush) begin
                q_instr.delete();
                q_pc.delete();
            end else begin
                if (sz > 0 && out_ready) begin
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    q_instr.push_back(in_instr);
                    q_pc.push_back(in_pc);
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
